// File: rtl/range_sum_caller.sv
// rtl/range_sum_caller.sv - caller-side wrapper that runs one range generator call and returns sum/count/truncated
//
// Launches a range generator with base/limit/step, accumulates every yielded
// value and reports the result through a one-cycle _valid/_ready pulse.
//
// Ports:
//   _clock, _reset           rising-edge clock, asynchronous active-high reset
//   base, limit, step        call arguments, latched when a call starts
//   _start, _wait            start request / downstream backpressure
//   _0, _1, _2               sum, count, truncated (driven only in the pulse cycle)
//   _ready, _valid           coincident one-cycle result pulse
//   _callee_base/limit/step  registered arguments to the generator
//   _callee_start            one-cycle call pulse to the generator
//   _callee_wait             stall to the generator (combinational)
//   _callee_0, _callee_valid yielded value and its pulse
//   _callee_ready            generator finished pulse
module range_sum_caller #(
  parameter int SUM_W     = 32,
  parameter int MAX_COUNT = 1024,
  parameter int THROTTLE  = 0
) (
  input  logic                    _clock,
  input  logic                    _reset,
  input  logic signed [31:0]      base,
  input  logic signed [31:0]      limit,
  input  logic signed [31:0]      step,
  input  logic                    _start,
  input  logic                    _wait,
  output logic signed [SUM_W-1:0] _0,
  output logic [31:0]             _1,
  output logic                    _2,
  output logic                    _ready,
  output logic                    _valid,
  output logic signed [31:0]      _callee_base,
  output logic signed [31:0]      _callee_limit,
  output logic signed [31:0]      _callee_step,
  output logic                    _callee_start,
  output logic                    _callee_wait,
  input  logic signed [31:0]      _callee_0,
  input  logic                    _callee_valid,
  input  logic                    _callee_ready
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]              state_q, state_d;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic [31:0]             count_q, count_d;
  logic                    trunc_q, trunc_d;
  logic [31:0]             thr_cnt_q, thr_cnt_d;
  logic                    stall_q, stall_d;
  logic signed [31:0]      arg_base_q, arg_base_d;
  logic signed [31:0]      arg_limit_q, arg_limit_d;
  logic signed [31:0]      arg_step_q, arg_step_d;
  logic                    cstart_q, cstart_d;
  logic                    pulse_q, pulse_d;
  logic signed [SUM_W-1:0] res_sum_q, res_sum_d;
  logic [31:0]             res_cnt_q, res_cnt_d;
  logic                    res_trunc_q, res_trunc_d;

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    count_d     = count_q;
    trunc_d     = trunc_q;
    thr_cnt_d   = thr_cnt_q;
    stall_d     = 1'b0;
    arg_base_d  = arg_base_q;
    arg_limit_d = arg_limit_q;
    arg_step_d  = arg_step_q;
    cstart_d    = 1'b0;
    pulse_d     = 1'b0;
    res_sum_d   = '0;
    res_cnt_d   = '0;
    res_trunc_d = 1'b0;

    // A new call wins over everything, including callee pulses arriving in
    // the same cycle from an abandoned call.
    if (_start && !_wait) begin
      arg_base_d  = base;
      arg_limit_d = limit;
      arg_step_d  = step;
      cstart_d    = 1'b1;
      sum_d       = '0;
      count_d     = '0;
      trunc_d     = 1'b0;
      thr_cnt_d   = '0;
      state_d     = S_COLLECT;
    end else begin
      case (state_q)
        S_COLLECT: begin
          // Capture is deliberately not gated by _wait: the callee may have
          // registered a pulse just before the stall took effect.
          if (_callee_valid) begin
            sum_d   = sum_q + SUM_W'(_callee_0);
            count_d = count_q + 32'd1;
            if (THROTTLE > 0) begin
              if (thr_cnt_q == 32'(THROTTLE - 1)) begin
                thr_cnt_d = '0;
                stall_d   = 1'b1;
              end else begin
                thr_cnt_d = thr_cnt_q + 32'd1;
              end
            end
            if (count_d == 32'(MAX_COUNT)) begin
              trunc_d = 1'b1;
              state_d = S_DONE;
            end
          end
          if (_callee_ready) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (!_wait) begin
            pulse_d     = 1'b1;
            res_sum_d   = sum_q;
            res_cnt_d   = count_q;
            res_trunc_d = trunc_q;
            state_d     = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      state_q     <= S_IDLE;
      sum_q       <= '0;
      count_q     <= '0;
      trunc_q     <= 1'b0;
      thr_cnt_q   <= '0;
      stall_q     <= 1'b0;
      arg_base_q  <= '0;
      arg_limit_q <= '0;
      arg_step_q  <= '0;
      cstart_q    <= 1'b0;
      pulse_q     <= 1'b0;
      res_sum_q   <= '0;
      res_cnt_q   <= '0;
      res_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      count_q     <= count_d;
      trunc_q     <= trunc_d;
      thr_cnt_q   <= thr_cnt_d;
      stall_q     <= stall_d;
      arg_base_q  <= arg_base_d;
      arg_limit_q <= arg_limit_d;
      arg_step_q  <= arg_step_d;
      cstart_q    <= cstart_d;
      pulse_q     <= pulse_d;
      res_sum_q   <= res_sum_d;
      res_cnt_q   <= res_cnt_d;
      res_trunc_q <= res_trunc_d;
    end
  end

  assign _0            = res_sum_q;
  assign _1            = res_cnt_q;
  assign _2            = res_trunc_q;
  assign _valid        = pulse_q;
  assign _ready        = pulse_q;
  assign _callee_base  = arg_base_q;
  assign _callee_limit = arg_limit_q;
  assign _callee_step  = arg_step_q;
  assign _callee_start = cstart_q;
  // Callee only runs while we are collecting, so it is frozen in IDLE/DONE.
  assign _callee_wait  = _wait | stall_q | (state_q != S_COLLECT);

endmodule

// File: tb/tb_range_sum_caller.sv
// tb/tb_range_sum_caller.sv - self-checking bench for range_sum_caller
module tb_range_sum_caller;

  logic clk = 1'b0;
  logic rst;
  logic signed [31:0] base, limit, step;
  logic start, dwait;

  always #5 clk = ~clk;

  logic signed [31:0] o_sum [3];
  logic [31:0]        o_cnt [3];
  logic               o_tr  [3];
  logic               o_vld [3];
  logic               o_rdy [3];
  logic               o_cst [3];
  logic               o_cw  [3];
  logic               c_rdy [3];
  logic               c_vld [3];
  logic signed [31:0] o_cb  [3];
  logic signed [31:0] o_cl  [3];
  logic signed [31:0] o_cs  [3];

  // Instance 0: defaults. Instance 1: THROTTLE=2. Instance 2: SUM_W=8, MAX_COUNT=4.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int SW = (g == 2) ? 8 : 32;
    localparam int MC = (g == 2) ? 4 : 1024;
    localparam int TH = (g == 1) ? 2 : 0;

    logic signed [SW-1:0] sum_raw;
    logic [31:0]          cnt;
    logic                 tr, vld, rdy, cst, cw;
    logic signed [31:0]   cb, cl, cs;
    logic signed [31:0]   y_val;
    logic                 y_vld, y_rdy;
    logic signed [31:0]   cur, lim, stp;
    logic                 busy;

    range_sum_caller #(.SUM_W(SW), .MAX_COUNT(MC), .THROTTLE(TH)) u_dut (
      ._clock(clk), ._reset(rst),
      .base(base), .limit(limit), .step(step),
      ._start(start), ._wait(dwait),
      ._0(sum_raw), ._1(cnt), ._2(tr), ._ready(rdy), ._valid(vld),
      ._callee_base(cb), ._callee_limit(cl), ._callee_step(cs),
      ._callee_start(cst), ._callee_wait(cw),
      ._callee_0(y_val), ._callee_valid(y_vld), ._callee_ready(y_rdy)
    );

    // Range generator model: one action (yield or finish) per unstalled cycle.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        y_val <= '0; y_vld <= 1'b0; y_rdy <= 1'b0;
        cur <= '0; lim <= '0; stp <= '0; busy <= 1'b0;
      end else begin
        y_vld <= 1'b0;
        y_rdy <= 1'b0;
        if (cst) begin
          lim <= cl;
          stp <= cs;
          if (cb < cl) begin
            y_vld <= 1'b1; y_val <= cb; cur <= cb + cs; busy <= 1'b1;
          end else begin
            y_rdy <= 1'b1; busy <= 1'b0; cur <= cb;
          end
        end else if (busy && !cw) begin
          if (cur < lim) begin
            y_vld <= 1'b1; y_val <= cur; cur <= cur + stp;
          end else begin
            y_rdy <= 1'b1; busy <= 1'b0;
          end
        end
      end
    end

    assign o_sum[g] = 32'(sum_raw);
    assign o_cnt[g] = cnt;
    assign o_tr[g]  = tr;
    assign o_vld[g] = vld;
    assign o_rdy[g] = rdy;
    assign o_cst[g] = cst;
    assign o_cw[g]  = cw;
    assign o_cb[g]  = cb;
    assign o_cl[g]  = cl;
    assign o_cs[g]  = cs;
    assign c_rdy[g] = y_rdy;
    assign c_vld[g] = y_vld;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", nm, $signed(act), act, $signed(exp), exp);
    end
  endtask

  typedef struct {
    logic signed [31:0] b, l, s;
    logic [2:0][31:0]   esum;
    logic [2:0][31:0]   ecnt;
    logic [2:0]         etr;
    logic [2:0][15:0]   elat;
    logic [31:0]        emask;
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mk(input int b, l, s, s0, s1, s2, c0, c1, c2,
                              t0, t1, t2, l0, l1, l2, input logic [31:0] m);
    vec_t v;
    v.b = b; v.l = l; v.s = s;
    v.esum[0] = s0; v.esum[1] = s1; v.esum[2] = s2;
    v.ecnt[0] = c0; v.ecnt[1] = c1; v.ecnt[2] = c2;
    v.etr[0] = t0[0]; v.etr[1] = t1[0]; v.etr[2] = t2[0];
    v.elat[0] = 16'(l0); v.elat[1] = 16'(l1); v.elat[2] = 16'(l2);
    v.emask = m;
    return v;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int np [3];
    int lat [3];
    logic [31:0] gs [3];
    logic [31:0] gc [3];
    logic gt [3];
    logic [31:0] mask;
    logic quiet_ok;
    int seen_cv, mx;
    mask = '0; quiet_ok = 1'b1; seen_cv = 0; mx = 0;
    for (int g = 0; g < 3; g++) begin
      np[g] = 0; lat[g] = -1; gs[g] = '0; gc[g] = '0; gt[g] = 1'b0;
      if (int'(v.elat[g]) > mx) mx = int'(v.elat[g]);
    end
    base = v.b; limit = v.l; step = v.s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk($sformatf("v%0d_call_args", idx),
        {31'd0, (o_cst[0] === 1'b1 && o_cb[0] === v.b && o_cl[0] === v.l && o_cs[0] === v.s)}, 32'd1);
    for (int c = 1; c <= mx + 3; c++) begin
      @(posedge clk); #1;
      if (c == 1 && o_cst[0] !== 1'b0) quiet_ok = 1'b0;
      if (c_vld[0]) seen_cv++;
      if (c <= 31 && c <= int'(v.elat[1]) - 2 && o_cw[1]) mask[c] = 1'b1;
      for (int g = 0; g < 3; g++) begin
        if (o_vld[g] !== o_rdy[g]) quiet_ok = 1'b0;
        if (o_vld[g]) begin
          np[g]++;
          if (lat[g] < 0) begin
            lat[g] = c; gs[g] = o_sum[g]; gc[g] = o_cnt[g]; gt[g] = o_tr[g];
          end
        end else if (o_sum[g] !== 0 || o_cnt[g] !== 0 || o_tr[g] !== 1'b0) begin
          quiet_ok = 1'b0;
        end
      end
    end
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("v%0d_i%0d_pulses", idx, g), np[g], 1);
      chk($sformatf("v%0d_i%0d_latency", idx, g), lat[g], 32'(v.elat[g]));
      chk($sformatf("v%0d_i%0d_sum", idx, g), gs[g], v.esum[g]);
      chk($sformatf("v%0d_i%0d_count", idx, g), gc[g], v.ecnt[g]);
      chk($sformatf("v%0d_i%0d_trunc", idx, g), {31'd0, gt[g]}, {31'd0, v.etr[g]});
    end
    chk($sformatf("v%0d_throttle_wait_cycles", idx), mask, v.emask);
    chk($sformatf("v%0d_quiet_outside_pulse", idx), {31'd0, quiet_ok}, 32'd1);
    if (v.ecnt[0] == 0) chk($sformatf("v%0d_no_callee_valid", idx), seen_cv, 0);
  endtask

  initial begin
    int early, prepulse, found, np0, np2, lat0;
    int at8 [3];
    logic [31:0] s0, c0, s2, c2;
    logic t0;

    rst = 1'b1; start = 1'b0; dwait = 1'b0; base = '0; limit = '0; step = '0;

    //              base limit step  sum i0,i1,i2     cnt i0,i1,i2     tr       lat i0,i1,i2    throttle mask
    vecs[0] = mk(  0,   5,  1,  10,  10,    6,    5,    5, 4,  0, 0, 1,    8,   10, 6, 32'h0000_0048);
    vecs[1] = mk(  3,   3,  1,   0,   0,    0,    0,    0, 0,  0, 0, 0,    3,    3, 3, 32'h0000_0000);
    vecs[2] = mk(-10,  10,  3,  -7,  -7,  -22,    7,    7, 4,  0, 0, 1,   10,   13, 6, 32'h0000_0248);
    vecs[3] = mk(  0,   6,  1,  15,  15,    6,    6,    6, 4,  0, 0, 1,    9,   11, 6, 32'h0000_0248);
    vecs[4] = mk(  0,   1,  0,   0,   0,    0, 1024, 1024, 4,  1, 1, 1, 1026, 1537, 6, 32'h4924_9248);
    vecs[5] = mk(100, 104,  1, 406, 406, -106,    4,    4, 4,  0, 0, 1,    7,    8, 6, 32'h0000_0048);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_sum", o_sum[0], 0);
    chk("reset_valid_ready", {30'd0, o_vld[0], o_rdy[0]}, 0);
    chk("reset_callee_start_args", {31'd0, (o_cst[0] | (|o_cb[0]) | (|o_cl[0]) | (|o_cs[0]))}, 0);
    chk("reset_callee_wait", {31'd0, o_cw[0]}, 1);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      run_vec(i, vecs[i]);
    end

    // Hold _wait high in DONE for 5 cycles on an empty range.
    base = 3; limit = 3; step = 1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; dwait = 1'b1;
    early = 0;
    for (int g = 0; g < 3; g++) at8[g] = 0;
    for (int c = 3; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 5) chk("hold_callee_wait", {31'd0, o_cw[0]}, 1);
      for (int g = 0; g < 3; g++) begin
        if (o_vld[g]) begin
          if (c < 8) early++;
          else at8[g] = 1;
        end
      end
      if (c == 7) dwait = 1'b0;
    end
    chk("hold_no_early_pulse", early, 0);
    for (int g = 0; g < 3; g++) chk($sformatf("hold_i%0d_release_pulse", g), at8[g], 1);
    repeat (5) @(posedge clk);
    #1;

    // Restart while the first call's callee_ready is arriving.
    base = 0; limit = 3; step = 1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    prepulse = 0; found = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (o_vld[0] || o_vld[2]) prepulse++;
      if (c_rdy[0]) begin
        found = c;
        break;
      end
    end
    chk("restart_first_ready_cycle", found, 4);
    base = 10; limit = 12; step = 1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    np0 = 0; np2 = 0; lat0 = -1; s0 = '0; c0 = '0; t0 = 1'b0; s2 = '0; c2 = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (o_vld[0]) begin
        np0++;
        if (lat0 < 0) begin lat0 = c; s0 = o_sum[0]; c0 = o_cnt[0]; t0 = o_tr[0]; end
      end
      if (o_vld[2]) begin
        np2++;
        s2 = o_sum[2]; c2 = o_cnt[2];
      end
    end
    chk("restart_no_pulse_first_call", prepulse, 0);
    chk("restart_i0_pulses", np0, 1);
    chk("restart_i0_latency", lat0, 5);
    chk("restart_i0_sum", s0, 21);
    chk("restart_i0_count", c0, 2);
    chk("restart_i0_trunc", {31'd0, t0}, 0);
    chk("restart_i2_pulses", np2, 1);
    chk("restart_i2_sum_count", {s2[15:0], c2[15:0]}, {16'd21, 16'd2});
    repeat (30) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a call.
    base = 7; limit = 20; step = 2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #2; rst = 1'b1;
    #1;
    chk("midrst_callee_args", {31'd0, ((|o_cb[0]) | (|o_cl[0]) | (|o_cs[0]))}, 0);
    chk("midrst_result", {31'd0, ((|o_sum[0]) | (|o_cnt[0]) | o_tr[0] | o_vld[0] | o_rdy[0] | o_cst[0])}, 0);
    chk("midrst_callee_wait", {31'd0, o_cw[0]}, 1);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    early = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 3; g++) if (o_vld[g] || o_rdy[g]) early++;
    end
    chk("midrst_no_pulse", early, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
